i8080_bus_ctrl: RTL and testbench

//  Parametrised system-bus controller between the i8080 core and memory/IO. Latches the

---
 rtl/i8080_bus_ctrl_pkg.sv | 37 +++
 rtl/i8080_bus_ctrl_wait_timer.sv | 34 +++
 rtl/i8080_bus_ctrl.sv | 178 +++++++++++++++++
 tb/tb_i8080_bus_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i8080_bus_ctrl_pkg.sv
// Shared constants for the i8080 system-bus controller:
// status bit positions, cycle types, FSM states, RST opcode base.
package i8080_bus_ctrl_pkg;

    localparam int STATUS_INTA = 0;
    localparam int STATUS_OUT  = 4;
    localparam int STATUS_INP  = 6;
    localparam int STATUS_MEMR = 7;

    localparam logic [7:0] RST_OPCODE = 8'hC7;

    typedef enum logic [1:0] {
        CYC_MEM,
        CYC_INP,
        CYC_OUT,
        CYC_INTA
    } cyc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    // INTA outranks IO; anything without an IO/INTA bit is a memory cycle.
    function automatic cyc_t cyc_decode(input logic [7:0] st);
        if (st[STATUS_INTA])
            return CYC_INTA;
        else if (st[STATUS_INP])
            return CYC_INP;
        else if (st[STATUS_OUT])
            return CYC_OUT;
        else
            return CYC_MEM;
    endfunction

endpackage

// File: rtl/i8080_bus_ctrl_wait_timer.sv
// Wait-state timer: 4-bit counter loaded at sync and
// decremented while waiting; done when it reaches zero.
module i8080_bus_ctrl_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load wins over decrement; the counter never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 4'd0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/i8080_bus_ctrl.sv
// i8080 system-bus controller: status latch, cycle decode, chip selects,
// strobes and wait states. Define I8080_BUS_IRQ_EN for RST-n interrupt support.
module i8080_bus_ctrl
    import i8080_bus_ctrl_pkg::*;
#(
    parameter int XLEN        = 8,
    parameter int NUM_REGIONS = 2,
    parameter int REGION_BITS = 13,
    parameter int MEM_WAIT    = 0,
    parameter int IO_WAIT     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sync,
    input  logic                   dbin,
    input  logic                   write_n,
    input  logic [2*XLEN-1:0]      addr,
    input  logic [XLEN-1:0]        data_in,
    output logic                   ready,
    output logic [NUM_REGIONS-1:0] mem_cs,
    output logic                   mem_oe,
    output logic                   mem_we,
    output logic [XLEN-1:0]        io_port,
    output logic                   io_rd,
    output logic                   io_wr,
    output logic                   inta,
    output logic                   bus_err,
    input  logic                   irq_req,
    input  logic [2:0]             irq_vec,
    output logic                   int_out,
    output logic                   vec_drive,
    output logic [XLEN-1:0]        vec_data
);

    localparam int AW = 2 * XLEN;
    localparam logic [3:0] MW = 4'(MEM_WAIT);
    localparam logic [3:0] IW = 4'(IO_WAIT);

    state_t          state_q, state_d;
    logic [XLEN-1:0] status_q, status_d;
    logic [XLEN-1:0] io_port_q, io_port_d;
    logic            err_q, err_d;

    cyc_t            cyc;
    cyc_t            new_cyc;
    logic [3:0]      new_waits;
    logic            accept;
    logic            t_load;
    logic [3:0]      t_val;
    logic            t_done;
    logic            busy;
    logic [AW-1:0]   region;

    assign new_cyc   = cyc_decode(data_in[7:0]);
    assign new_waits = (new_cyc == CYC_INP || new_cyc == CYC_OUT) ? IW : MW;
    assign accept    = sync && (state_q != S_WAIT);
    assign cyc       = cyc_decode(status_q[7:0]);
    assign busy      = (state_q != S_IDLE);
    assign region    = addr >> REGION_BITS;

    i8080_bus_ctrl_wait_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .dec      (state_q == S_WAIT),
        .done     (t_done)
    );

    // Next state: accept sync outside S_WAIT, flag it as an error inside.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        io_port_d = io_port_q;
        err_d     = err_q;
        t_load    = 1'b0;
        t_val     = 4'd0;
        unique case (state_q)
            S_IDLE, S_ACCESS: begin
                if (sync) begin
                    status_d  = data_in;
                    io_port_d = addr[XLEN-1:0];
                    if (new_waits != 4'd0) begin
                        state_d = S_WAIT;
                        t_load  = 1'b1;
                        t_val   = new_waits - 4'd1;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (sync)
                    err_d = 1'b1;
                if (t_done)
                    state_d = S_ACCESS;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            status_q  <= '0;
            io_port_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            io_port_q <= io_port_d;
            err_q     <= err_d;
        end
    end

    // Strobes: chip select follows the cycle; data strobes wait for ready.
    always_comb begin
        mem_cs = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            mem_cs[i] = busy && (cyc == CYC_MEM) && (region == AW'(i));
        ready  = (state_q != S_WAIT);
        mem_oe = (|mem_cs) && dbin && ready;
        mem_we = (|mem_cs) && !write_n && ready;
        io_rd  = busy && (cyc == CYC_INP) && dbin && ready;
        io_wr  = busy && (cyc == CYC_OUT) && !write_n && ready;
        inta   = busy && (cyc == CYC_INTA);
    end

    assign io_port = io_port_q;
    assign bus_err = err_q;

`ifdef I8080_BUS_IRQ_EN
    logic irq_q, irq_d;
    logic pend_q, pend_d;
    logic served_q, served_d;

    assign vec_drive = inta && dbin;
    assign vec_data  = vec_drive ?
        XLEN'(RST_OPCODE | {2'b00, irq_vec, 3'b000}) : '0;
    assign int_out   = pend_q;

    // Pending clears on the sync after a served INTA; a new edge wins.
    always_comb begin
        irq_d    = irq_req;
        served_d = served_q;
        pend_d   = pend_q;
        if (accept)
            served_d = 1'b0;
        else if (vec_drive)
            served_d = 1'b1;
        if (accept && served_q)
            pend_d = 1'b0;
        if (irq_req && !irq_q)
            pend_d = 1'b1;
    end

    // Interrupt request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q    <= 1'b0;
            pend_q   <= 1'b0;
            served_q <= 1'b0;
        end else begin
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            served_q <= served_d;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^{irq_req, irq_vec, accept};
    assign int_out    = 1'b0;
    assign vec_drive  = 1'b0;
    assign vec_data   = '0;
`endif

endmodule

// File: tb/tb_i8080_bus_ctrl.sv
// Bench for i8080_bus_ctrl (IO_WAIT=2): directed cycles, a
// cycle-level bus model checked every negedge, plus literal checks.
module tb_i8080_bus_ctrl;

`ifdef I8080_BUS_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    localparam int MEM_W = 0;
    localparam int IO_W  = 2;

    logic        clk;
    logic        rst;
    logic        sync;
    logic        dbin;
    logic        write_n;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        ready;
    logic [1:0]  mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  io_port;
    logic        io_rd;
    logic        io_wr;
    logic        inta;
    logic        bus_err;
    logic        irq_req;
    logic [2:0]  irq_vec;
    logic        int_out;
    logic        vec_drive;
    logic [7:0]  vec_data;

    int total = 0;
    int bad   = 0;

    i8080_bus_ctrl #(.IO_WAIT(IO_W), .MEM_WAIT(MEM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sync      (sync),
        .dbin      (dbin),
        .write_n   (write_n),
        .addr      (addr),
        .data_in   (data_in),
        .ready     (ready),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .io_port   (io_port),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .inta      (inta),
        .bus_err   (bus_err),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .int_out   (int_out),
        .vec_drive (vec_drive),
        .vec_data  (vec_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Bus model: 0=mem 1=in 2=out 3=inta
    function automatic int ctype(input logic [7:0] s);
        if (s[0]) return 3;
        if (s[6]) return 1;
        if (s[4]) return 2;
        return 0;
    endfunction

    int         m_lows   = 0;
    bit         m_act    = 0;
    logic [7:0] m_st     = 0;
    logic [7:0] m_port   = 0;
    bit         m_err    = 0;
    bit         m_pend   = 0;
    bit         m_served = 0;
    bit         m_irqp   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lows = 0; m_act = 0; m_st = 0; m_port = 0;
            m_err = 0; m_pend = 0; m_served = 0; m_irqp = 0;
        end else begin
            bit edge_seen;
            edge_seen = irq_req && !m_irqp;
            m_irqp    = irq_req;
            if (sync && m_lows == 0) begin
                if (m_served) m_pend = 0;
                m_served = 0;
                m_st     = data_in;
                m_port   = addr[7:0];
                m_act    = 1;
                m_lows   = (ctype(data_in) == 1 || ctype(data_in) == 2)
                           ? IO_W : MEM_W;
            end else begin
                if (sync) m_err = 1;
                if (m_act && ctype(m_st) == 3 && dbin) m_served = 1;
                if (m_lows > 0) m_lows--;
            end
            if (edge_seen) m_pend = 1;
        end
    end

    always @(negedge clk) begin
        int   t;
        int   rg;
        bit   rdy;
        bit   vd;
        logic [1:0] cs;
        t   = ctype(m_st);
        rdy = (m_lows == 0);
        rg  = int'(addr) / 8192;
        cs  = 2'b00;
        if (m_act && t == 0 && rg < 2) cs[rg] = 1'b1;
        vd  = IRQ && m_act && t == 3 && dbin;
        chk("m_ready", 32'(ready), 32'(rdy));
        chk("m_mem_cs", 32'(mem_cs), 32'(cs));
        chk("m_mem_oe", 32'(mem_oe), 32'(cs != 0 && dbin && rdy));
        chk("m_mem_we", 32'(mem_we), 32'(cs != 0 && !write_n && rdy));
        chk("m_io_port", 32'(io_port), 32'(m_port));
        chk("m_io_rd", 32'(io_rd), 32'(m_act && t == 1 && dbin && rdy));
        chk("m_io_wr", 32'(io_wr), 32'(m_act && t == 2 && !write_n && rdy));
        chk("m_inta", 32'(inta), 32'(m_act && t == 3));
        chk("m_bus_err", 32'(bus_err), 32'(m_err));
        chk("m_int_out", 32'(int_out), 32'(IRQ && m_pend));
        chk("m_vec_drive", 32'(vec_drive), 32'(vd));
        chk("m_vec_data", 32'(vec_data), vd ? 32'(8'hC7 + irq_vec * 8) : 0);
    end

    task automatic cyc(input logic s, input logic rd, input logic wn,
                       input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        sync = s; dbin = rd; write_n = wn; addr = a; data_in = d;
    endtask

    initial begin
        rst = 1'b1; sync = 0; dbin = 0; write_n = 1;
        addr = 0; data_in = 0; irq_req = 0; irq_vec = 3'd3;
        #3;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_cs", 32'(mem_cs), 0);
        chk("rst_port", 32'(io_port), 0);
        chk("rst_err", 32'(bus_err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // memory read, region 0, no waits
        cyc(1, 0, 1, 16'h0100, 8'h80);
        cyc(0, 1, 1, 16'h0100, 8'h00);
        #2;
        chk("t1_cs", 32'(mem_cs), 32'h1);
        chk("t1_oe", 32'(mem_oe), 1);
        chk("t1_ready", 32'(ready), 1);

        // memory write, region 1
        cyc(1, 0, 1, 16'h2000, 8'h00);
        cyc(0, 0, 0, 16'h2000, 8'h00);
        #2;
        chk("wr_cs", 32'(mem_cs), 32'h2);
        chk("wr_we", 32'(mem_we), 1);

        // unmapped read
        cyc(1, 0, 1, 16'h4000, 8'h80);
        cyc(0, 1, 1, 16'h4000, 8'h00);
        #2;
        chk("t3_cs", 32'(mem_cs), 0);
        chk("t3_oe", 32'(mem_oe), 0);
        chk("t3_err", 32'(bus_err), 0);

        // OUT with two wait states
        cyc(1, 0, 1, 16'h0005, 8'h10);
        cyc(0, 0, 0, 16'h0005, 8'h00);
        #2;
        chk("t2_rdy0", 32'(ready), 0);
        chk("t2_wr0", 32'(io_wr), 0);
        chk("t2_port", 32'(io_port), 32'h05);
        cyc(0, 0, 0, 16'h0005, 8'h00);
        #2;
        chk("t2_rdy1", 32'(ready), 0);
        cyc(0, 0, 0, 16'h0005, 8'h00);
        #2;
        chk("t2_rdy2", 32'(ready), 1);
        chk("t2_wr2", 32'(io_wr), 1);

        // IN, with a stray sync during the wait states
        cyc(1, 0, 1, 16'h0007, 8'h40);
        cyc(1, 1, 1, 16'h0007, 8'h80);
        #2;
        chk("t4_rdy", 32'(ready), 0);
        cyc(0, 1, 1, 16'h0007, 8'h00);
        #2;
        chk("t4_err", 32'(bus_err), 1);
        cyc(0, 1, 1, 16'h0007, 8'h00);
        #2;
        chk("t4_rd", 32'(io_rd), 1);
        chk("t4_cs", 32'(mem_cs), 0);
        chk("t4_port", 32'(io_port), 32'h07);

        // interrupt request and INTA
        cyc(0, 0, 1, 16'h0007, 8'h00);
        irq_req = 1'b1;
        cyc(0, 0, 1, 16'h0007, 8'h00);
        irq_req = 1'b0;
        #2;
        chk("t5_int", 32'(int_out), 32'(IRQ));
        cyc(1, 0, 1, 16'h0038, 8'h23);
        cyc(0, 1, 1, 16'h0038, 8'h00);
        #2;
        chk("t5_inta", 32'(inta), 1);
        chk("t5_vdrv", 32'(vec_drive), 32'(IRQ));
        chk("t5_vdat", 32'(vec_data), IRQ ? 32'hDF : 0);
        cyc(0, 0, 1, 16'h0038, 8'h00);
        #2;
        chk("t5_int_hold", 32'(int_out), 32'(IRQ));
        cyc(1, 0, 1, 16'h0100, 8'h80);
        cyc(0, 1, 1, 16'h0100, 8'h00);
        #2;
        chk("t5_int_clr", 32'(int_out), 0);
        chk("t5_err_sticky", 32'(bus_err), 1);

        // reset during wait states
        cyc(1, 0, 1, 16'h0009, 8'h10);
        cyc(0, 0, 0, 16'h0009, 8'h00);
        #1;
        chk("t6_rdy0", 32'(ready), 0);
        rst = 1'b1;
        #1;
        chk("t6_rdy", 32'(ready), 1);
        chk("t6_wr", 32'(io_wr), 0);
        chk("t6_cs", 32'(mem_cs), 0);
        chk("t6_err", 32'(bus_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("t6_idle_we", 32'(mem_we), 0);
        chk("t6_idle_rdy", 32'(ready), 1);
        cyc(1, 1, 1, 16'h0100, 8'h80);
        cyc(0, 1, 1, 16'h0100, 8'h00);
        #2;
        chk("t6_cs_after", 32'(mem_cs), 32'h1);
        chk("t6_oe_after", 32'(mem_oe), 1);
        cyc(0, 0, 1, 16'h0100, 8'h00);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
